frame_header_rx: RTL and testbench
==================================

Name: frame_header_rx

Overview:
- Receive-side counterpart to the transmit header inserter on the 2-bit, 50 MHz dibit stream.
- Sits after preamble/SFD removal. Parses the Ethernet header (destination MAC, source MAC, ethertype), filters frames on address and ethertype, and forwards only payload dibits downstream.
- Reports header outcome and payload length so later stages (CRC check, aggregator) can act on whole frames.

Parameters:
- MY_ADDR, 48'h69695A065491, unicast address this station accepts.
- ACCEPT_BCAST, 1, when 1 also accept destination 48'hFFFFFFFFFFFF.
- ETHERTYPE, 16'h0101, only ethertype forwarded.

Ports:
- clk  input  1  50 MHz clock
- rst  input  1  system reset; asynchronous, active-high
- axiiv  input  1  input dibit valid; high for the whole frame, low at least 1 cycle between frames
- axiid  input  2  input dibit
- axiov  output  1  payload dibit valid
- axiod  output  2  payload dibit
- src_addr  output  48  source MAC of the last accepted frame; held until the next acceptance
- hdr_ok  output  1  1-cycle pulse when the header is accepted
- drop  output  1  1-cycle pulse when a frame is rejected (address or ethertype)
- runt  output  1  1-cycle pulse when axiiv falls before the header completes
- eof  output  1  1-cycle pulse when an accepted frame ends
- payload_dibits  output  16  dibit count of the accepted payload; valid when eof is high, held afterwards

Behaviour:
- Bit order: MSB-first across each field. The first dibit of a field is bits [W-1:W-2]. Shift in as {shreg[W-3:0], axiid}.
- Reset (async, rst=1):
  - axiov=0, axiod=0, hdr_ok=drop=runt=eof=0.
  - src_addr=0, payload_dibits=0.
  - Counters 0, state IDLE.
  - Asserting reset mid-frame aborts immediately. After release the block waits in IDLE for axiiv low, then high.
- States:
  - IDLE: axiiv=1 captures dest dibit 0, cnt<=1, go DEST.
  - DEST: shift dibits; cnt counts 0..23. On dibit 23 (cnt==23), compare the full 48-bit value (shreg combined with the current dibit) against MY_ADDR, and against all-ones if ACCEPT_BCAST. Match: go SOURCE, cnt<=0. Mismatch: drop pulse next cycle, go DROP.
  - SOURCE: 24 dibits shifted into a src shift register. On dibit 23, go ETHER.
  - ETHER: 8 dibits. On dibit 7, compare with ETHERTYPE.
    - Match: load src_addr, pulse hdr_ok on the next cycle, payload_dibits<=0, go PAYLOAD.
    - Mismatch: pulse drop, go DROP.
  - PAYLOAD: registered pass-through with latency 1. axiov<=axiiv, axiod<=axiid, payload_dibits<=payload_dibits+1 (saturates at 16'hFFFF). When axiiv=0: axiov<=0, axiod<=0, eof pulse in that same cycle, go IDLE.
  - DROP: ignore data, axiov=0. On axiiv=0 go IDLE.
  - WAITGAP: entered after reset release if axiiv=1. On axiiv=0 go IDLE.
- Runt condition: axiiv=0 in DEST/SOURCE/ETHER produces a runt pulse next cycle and a return to IDLE. No drop pulse, src_addr unchanged.
- Payload dibit timing:
  - The first forwarded dibit is the one sampled the cycle after ethertype dibit 7.
  - axiov first rises 2 cycles after ethertype dibit 7 (1 cycle decision, 1 cycle pipeline); hdr_ok rises 1 cycle after ethertype dibit 7, i.e. 1 cycle before axiov.
- A zero-length payload (axiiv falls right after the ethertype) gives hdr_ok followed by eof with payload_dibits=0 and no axiov.
- axiod is 0 whenever axiov=0.
- Pulse exclusivity: drop, runt and eof are mutually exclusive. At most one of hdr_ok/drop/runt occurs per frame.
- An idle cycle between frames is required. axiiv staying high across two frames is treated as one frame.

Test Plan:
- Broadcast: dest FF..FF, src 69695A065490, type 0101, payload 8 dibits 0,1,2,3,3,2,1,0. Expect:
  - hdr_ok once.
  - axiov high 8 cycles with the same sequence, delayed 1 cycle.
  - eof with payload_dibits=8.
  - src_addr=48'h69695A065490.
- Unicast: dest 69695A065491 accepted. Dest 69695A065492 gives a drop pulse, axiov never rises, src_addr unchanged.
- Ethertype 0800 with a valid broadcast dest: drop pulse after ethertype dibit 7, no axiov, no eof.
- axiiv low after 30 header dibits: runt pulse, back to IDLE. The next valid frame is accepted normally.
- Reset asserted during payload dibit 4: all outputs 0 asynchronously. With axiiv still high after release, no output until axiiv goes low then a fresh frame starts.
- Zero-length payload: hdr_ok, then eof with payload_dibits=0, axiov stays 0. ACCEPT_BCAST=0 instance drops a broadcast frame.

Source files
------------

// File: rtl/frame_header_rx_if.sv
// Dibit stream bundle: upstream (axiiv/axiid) into the parser, payload (axiov/axiod) out of it.
interface frame_header_rx_if;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;

    modport master (output axiiv, axiid, input axiov, axiod);
    modport slave  (input axiiv, axiid, output axiov, axiod);
endinterface

// File: rtl/frame_header_rx.sv
// Ethernet header parser on the 2-bit dibit stream: filters on dest MAC and ethertype,
// forwards payload dibits with one cycle of latency and reports per-frame outcome.
module frame_header_rx #(
    parameter logic [47:0] MY_ADDR      = 48'h69695A065491,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter logic [15:0] ETHERTYPE    = 16'h0101
) (
    input  logic               clk,
    input  logic               rst,
    frame_header_rx_if.slave   strm,
    output logic [47:0]        src_addr,
    output logic               hdr_ok,
    output logic               drop,
    output logic               runt,
    output logic               eof,
    output logic [15:0]        payload_dibits
);

    typedef enum logic [2:0] {IDLE, DEST, SOURCE, ETHER, PAYLOAD, DROP, WAITGAP} state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic        post_rst;
    logic [45:0] dst_sr;
    logic [47:0] src_sr;
    logic        hdr_ok_n, drop_n, runt_n, eof_n;
    logic        shift_dst, shift_src, load_src, fwd;
    logic [47:0] dest_full;
    logic        addr_hit, type_hit;

    // Last dibit of a field is compared combined with the shift register, not after it lands.
    assign dest_full = {dst_sr, strm.axiid};
    assign addr_hit  = (dest_full == MY_ADDR) || (ACCEPT_BCAST && (dest_full == 48'hFFFF_FFFF_FFFF));
    assign type_hit  = ({dst_sr[13:0], strm.axiid} == ETHERTYPE);
    assign fwd       = (state == PAYLOAD) && strm.axiiv;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hdr_ok_n  = 1'b0;
        drop_n    = 1'b0;
        runt_n    = 1'b0;
        eof_n     = 1'b0;
        shift_dst = 1'b0;
        shift_src = 1'b0;
        load_src  = 1'b0;
        case (state)
            IDLE: if (strm.axiiv) begin
                // A frame already in flight when reset released is skipped whole.
                if (post_rst) state_n = WAITGAP;
                else begin
                    shift_dst = 1'b1;
                    cnt_n     = 5'd1;
                    state_n   = DEST;
                end
            end
            DEST: if (!strm.axiiv) begin
                runt_n = 1'b1; cnt_n = 5'd0; state_n = IDLE;
            end else begin
                shift_dst = 1'b1;
                if (cnt == 5'd23) begin
                    cnt_n = 5'd0;
                    if (addr_hit) state_n = SOURCE;
                    else begin drop_n = 1'b1; state_n = DROP; end
                end else cnt_n = cnt + 5'd1;
            end
            SOURCE: if (!strm.axiiv) begin
                runt_n = 1'b1; cnt_n = 5'd0; state_n = IDLE;
            end else begin
                shift_src = 1'b1;
                if (cnt == 5'd23) begin cnt_n = 5'd0; state_n = ETHER; end
                else cnt_n = cnt + 5'd1;
            end
            ETHER: if (!strm.axiiv) begin
                runt_n = 1'b1; cnt_n = 5'd0; state_n = IDLE;
            end else begin
                shift_dst = 1'b1;
                if (cnt == 5'd7) begin
                    cnt_n = 5'd0;
                    if (type_hit) begin
                        load_src = 1'b1; hdr_ok_n = 1'b1; state_n = PAYLOAD;
                    end else begin
                        drop_n = 1'b1; state_n = DROP;
                    end
                end else cnt_n = cnt + 5'd1;
            end
            PAYLOAD: if (!strm.axiiv) begin eof_n = 1'b1; state_n = IDLE; end
            DROP, WAITGAP: if (!strm.axiiv) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            post_rst       <= 1'b1;
            dst_sr         <= '0;
            src_sr         <= '0;
            src_addr       <= '0;
            payload_dibits <= '0;
            hdr_ok         <= 1'b0;
            drop           <= 1'b0;
            runt           <= 1'b0;
            eof            <= 1'b0;
            strm.axiov     <= 1'b0;
            strm.axiod     <= 2'b00;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            post_rst <= 1'b0;
            hdr_ok   <= hdr_ok_n;
            drop     <= drop_n;
            runt     <= runt_n;
            eof      <= eof_n;
            if (shift_dst) dst_sr <= {dst_sr[44:0], strm.axiid};
            if (shift_src) src_sr <= {src_sr[45:0], strm.axiid};
            if (load_src)  src_addr <= src_sr;
            if (load_src)
                payload_dibits <= '0;
            else if (fwd && payload_dibits != 16'hFFFF)
                payload_dibits <= payload_dibits + 16'd1;
            strm.axiov <= fwd;
            strm.axiod <= fwd ? strm.axiid : 2'b00;
        end
    end

endmodule

// File: tb/tb_frame_header_rx.sv
// Randomized and directed frames driven into two parser instances (broadcast on/off),
// checked against a frame-level outcome model.
module tb_frame_header_rx;
  localparam logic [47:0] MY = 48'h69695A065491;
  localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ET = 16'h0101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  frame_header_rx_if if0();
  frame_header_rx_if if1();
  assign if1.axiiv = if0.axiiv;
  assign if1.axiid = if0.axiid;

  logic [47:0] src[2];
  logic        hdr[2], drp[2], rnt[2], eofs[2], ov[2];
  logic [1:0]  od[2];
  logic [15:0] plen[2];
  assign ov[0] = if0.axiov;  assign od[0] = if0.axiod;
  assign ov[1] = if1.axiov;  assign od[1] = if1.axiod;

  frame_header_rx #(.MY_ADDR(MY), .ACCEPT_BCAST(1'b1), .ETHERTYPE(ET)) u_dut0 (
    .clk(clk), .rst(rst), .strm(if0), .src_addr(src[0]), .hdr_ok(hdr[0]), .drop(drp[0]),
    .runt(rnt[0]), .eof(eofs[0]), .payload_dibits(plen[0]));
  frame_header_rx #(.MY_ADDR(MY), .ACCEPT_BCAST(1'b0), .ETHERTYPE(ET)) u_dut1 (
    .clk(clk), .rst(rst), .strm(if1), .src_addr(src[1]), .hdr_ok(hdr[1]), .drop(drp[1]),
    .runt(rnt[1]), .eof(eofs[1]), .payload_dibits(plen[1]));

  // Output monitor: counts pulses and collects forwarded dibits.
  int cyc = 0;
  int n_hdr[2] = '{0, 0}, n_drop[2] = '{0, 0}, n_runt[2] = '{0, 0}, n_eof[2] = '{0, 0};
  int bad_od[2] = '{0, 0}, hdr_cyc[2] = '{0, 0}, ovf_cyc[2] = '{0, 0}, eof_cyc[2] = '{0, 0};
  bit ov_prev[2] = '{0, 0};
  logic [1:0] dq0[$], dq1[$];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (hdr[i]) begin n_hdr[i]++; hdr_cyc[i] = cyc; end
      if (drp[i]) n_drop[i]++;
      if (rnt[i]) n_runt[i]++;
      if (eofs[i]) begin n_eof[i]++; eof_cyc[i] = cyc; end
      if (ov[i] && !ov_prev[i]) ovf_cyc[i] = cyc;
      if (!ov[i] && od[i] != 2'b00) bad_od[i]++;
      if (ov[i]) begin
        if (i == 0) dq0.push_back(od[i]); else dq1.push_back(od[i]);
      end
      ov_prev[i] = ov[i];
    end
  end

  int checks = 0, errors = 0;
  logic [47:0] exp_src[2] = '{48'h0, 48'h0};
  logic [15:0] exp_len[2] = '{16'h0, 16'h0};
  logic [1:0]  pay[$];
  logic [1:0]  fr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level rule: 0 = runt, 1 = drop, 2 = accepted.
  function automatic int outcome(logic [47:0] d, logic [15:0] t, int sent, bit bc);
    bit aok = (d == MY) || (bc && d == BC);
    if (sent < 24) return 0;
    if (!aok) return 1;
    if (sent < 56) return 0;
    if (t != ET) return 1;
    return 2;
  endfunction

  task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    fr.delete();
    for (int k = 23; k >= 0; k--) fr.push_back(d[2*k+1 -: 2]);
    for (int k = 23; k >= 0; k--) fr.push_back(s[2*k+1 -: 2]);
    for (int k = 7; k >= 0; k--)  fr.push_back(t[2*k+1 -: 2]);
    foreach (pay[k]) fr.push_back(pay[k]);
  endtask

  task automatic drv(input logic v, input logic [1:0] d);
    @(negedge clk);
    if0.axiiv = v;
    if0.axiid = d;
  endtask

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int sent_req);
    int sh[2], sd[2], sr[2], se[2], sb[2], sq[2];
    int sent, oc, paysent, n_got;
    logic [1:0] got;
    build(d, s, t);
    sent = (sent_req < 0 || sent_req > fr.size()) ? fr.size() : sent_req;
    for (int i = 0; i < 2; i++) begin
      sh[i] = n_hdr[i]; sd[i] = n_drop[i]; sr[i] = n_runt[i]; se[i] = n_eof[i]; sb[i] = bad_od[i];
    end
    sq[0] = dq0.size(); sq[1] = dq1.size();
    for (int j = 0; j < sent; j++) drv(1'b1, fr[j]);
    for (int j = 0; j < 4; j++) drv(1'b0, 2'($urandom_range(0, 3)));
    @(posedge clk); #2;
    paysent = (sent > 56) ? sent - 56 : 0;
    for (int i = 0; i < 2; i++) begin
      oc = outcome(d, t, sent, i == 0);
      chk($sformatf("u%0d hdr_ok count", i), n_hdr[i] - sh[i], (oc == 2) ? 1 : 0);
      chk($sformatf("u%0d drop count", i), n_drop[i] - sd[i], (oc == 1) ? 1 : 0);
      chk($sformatf("u%0d runt count", i), n_runt[i] - sr[i], (oc == 0) ? 1 : 0);
      chk($sformatf("u%0d eof count", i), n_eof[i] - se[i], (oc == 2) ? 1 : 0);
      chk($sformatf("u%0d axiod idle zero", i), bad_od[i] - sb[i], 0);
      n_got = (i == 0) ? dq0.size() - sq[0] : dq1.size() - sq[1];
      chk($sformatf("u%0d payload count", i), n_got, (oc == 2) ? paysent : 0);
      if (oc == 2 && n_got == paysent) begin
        for (int k = 0; k < paysent; k++) begin
          got = (i == 0) ? dq0[sq[0] + k] : dq1[sq[1] + k];
          chk($sformatf("u%0d payload[%0d]", i, k), got, pay[k]);
        end
      end
      if (oc == 2) begin
        exp_src[i] = s;
        exp_len[i] = 16'(paysent);
        if (paysent > 0) chk($sformatf("u%0d hdr_ok->axiov", i), ovf_cyc[i] - hdr_cyc[i], 1);
        chk($sformatf("u%0d hdr_ok->eof", i), eof_cyc[i] - hdr_cyc[i], paysent + 1);
      end
      chk($sformatf("u%0d src_addr", i), src[i], exp_src[i]);
      chk($sformatf("u%0d payload_dibits", i), plen[i], exp_len[i]);
    end
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back(2'($urandom_range(0, 3)));
  endtask

  initial begin
    logic [47:0] d, s;
    logic [15:0] t;
    int sent;
    int sh[2], sd[2], sr[2], se[2], sq[2];
    if0.axiiv = 1'b0;
    if0.axiid = 2'b00;
    drv(1'b0, 2'b00);
    drv(1'b0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset ctl", i), {ov[i], od[i], hdr[i], drp[i], rnt[i], eofs[i]}, 0);
      chk($sformatf("u%0d reset src", i), src[i], 0);
      chk($sformatf("u%0d reset len", i), plen[i], 0);
    end
    @(negedge clk); rst = 1'b0;
    drv(1'b0, 2'b00);

    // Broadcast with fixed payload (instance 1 must drop it).
    pay = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    send_frame(BC, 48'h69695A065490, ET, -1);
    // Unicast accept, then near-miss unicast drop.
    rand_pay(5);  send_frame(MY, 48'h123456789ABC, ET, -1);
    rand_pay(5);  send_frame(48'h69695A065492, 48'hDEADBEEF0001, ET, -1);
    // Wrong ethertype.
    rand_pay(4);  send_frame(BC, 48'hCAFE00000002, 16'h0800, -1);
    // Runt after 30 dibits, then a normal frame.
    rand_pay(4);  send_frame(BC, 48'h0BADF00D0003, ET, 30);
    rand_pay(6);  send_frame(MY, 48'h0000AAAA5555, ET, -1);
    // Zero-length payload.
    pay.delete(); send_frame(MY, 48'h111122223333, ET, -1);

    // Reset during payload dibit 4, then a valid-looking stream while axiiv stays high.
    rand_pay(8);
    build(MY, 48'h444455556666, ET);
    for (int j = 0; j < 60; j++) drv(1'b1, fr[j]);
    @(negedge clk); if0.axiiv = 1'b1; if0.axiid = 2'b11;
    #5 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d async reset ctl", i), {ov[i], od[i], hdr[i], drp[i], rnt[i], eofs[i]}, 0);
      chk($sformatf("u%0d async reset src", i), src[i], 0);
      chk($sformatf("u%0d async reset len", i), plen[i], 0);
      exp_src[i] = 48'h0;
      exp_len[i] = 16'h0;
    end
    for (int j = 0; j < 3; j++) drv(1'b1, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 2; i++) begin
      sh[i] = n_hdr[i]; sd[i] = n_drop[i]; sr[i] = n_runt[i]; se[i] = n_eof[i];
    end
    sq[0] = dq0.size(); sq[1] = dq1.size();
    @(negedge clk); rst = 1'b0; if0.axiiv = 1'b1; if0.axiid = 2'b10;
    build(MY, 48'h777788889999, ET);
    foreach (fr[j]) drv(1'b1, fr[j]);
    for (int j = 0; j < 4; j++) drv(1'b0, 2'b00);
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d post-reset silent pulses", i),
          (n_hdr[i] - sh[i]) + (n_drop[i] - sd[i]) + (n_runt[i] - sr[i]) + (n_eof[i] - se[i]), 0);
      chk($sformatf("u%0d post-reset silent data", i),
          (i == 0) ? dq0.size() - sq[0] : dq1.size() - sq[1], 0);
      chk($sformatf("u%0d post-reset src", i), src[i], 0);
    end
    rand_pay(7);  send_frame(MY, 48'hABCDEF012345, ET, -1);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: d = MY;
        1: d = BC;
        2: d = MY ^ (48'h1 << $urandom_range(0, 47));
        default: d = {16'($urandom), 32'($urandom)};
      endcase
      s = {16'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0, 1: t = ET;
        2: t = 16'h0800;
        default: t = 16'($urandom);
      endcase
      rand_pay($urandom_range(0, 12));
      sent = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 55)) : -1;
      send_frame(d, s, t, sent);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
